sr_latch_driver: RTL and testbench
==================================

// Module: sr_latch_driver
// PURPOSE
//  Synchronous command-side driver for an SR latch (sr_latch): turns set/reset
//  commands (valid/ready) into clean s/r pulses with fixed width and dead time.
//  Never drives s=r=1. Reads q back after settling and flags mismatch.
//  Sits between control logic and the latch; q_exp mirrors the expected latch state.
// PARAMETERS
//  PULSE_W         2  s/r pulse width in clk cycles (>=1)
//  GAP_W           1  dead cycles after pulse before q check, s=r=0 (>=1)
//  SKIP_REDUNDANT  1  1: cmd equal to known q_exp issues no pulse
// PORTS
//  clk        in   1  clock, all state on rising edge
//  rst        in   1  synchronous reset, active-high
//  cmd_valid  in   1  command offered
//  cmd_set    in   1  1=SET (q->1), 0=RESET (q->0); valid with cmd_valid
//  cmd_ready  out  1  high only in IDLE; accept = cmd_valid & cmd_ready
//  s          out  1  latch set drive, registered
//  r          out  1  latch reset drive, registered
//  q_fb       in   1  latch q read back, sampled only in CHECK
//  busy       out  1  state != IDLE
//  done       out  1  1-cycle pulse in CHECK (command complete)
//  q_exp      out  1  expected latch state after last completed command
//  err        out  1  sticky: q_fb != commanded value at some CHECK
// BEHAVIOUR
//  Reset (any state, same edge): state=IDLE, s=r=0, done=0, err=0,
//   q_exp=0, known=0 (latch state unknown), counter=0; pending op dropped.
//  FSM: IDLE -> PULSE -> GAP -> CHECK -> IDLE; skip path IDLE -> CHECK.
//  IDLE: cmd_ready=1. On accept latch cmd_set into cmd_q.
//   If SKIP_REDUNDANT & known & cmd_set==q_exp -> CHECK (no pulse).
//   Else -> PULSE, counter=PULSE_W-1, s<=cmd_set, r<=~cmd_set.
//  PULSE: hold s/r; when counter==0 -> GAP, s=r=0, counter=GAP_W-1; else dec.
//  GAP: s=r=0; counter==0 -> CHECK; else dec.
//  CHECK (1 cycle): done=1, cmd_ready=0; if q_fb!=cmd_q set err;
//   q_exp<=cmd_q, known<=1; -> IDLE.
//  Timing, accept at edge 0: s or r high cycles 1..PULSE_W; gap cycles
//   PULSE_W+1..PULSE_W+GAP_W; done at cycle PULSE_W+GAP_W+1; next accept
//   no earlier than cycle PULSE_W+GAP_W+2. Skip path: done at cycle 1.
//  Invariants: s&r==0 every cycle; at most one of s/r toggles per edge;
//   cmd_valid ignored while busy (no queueing); err cleared only by rst.
//  q_fb is sampled raw; GAP_W must cover latch settle time.
//  Counter width: $clog2(max(PULSE_W,GAP_W)+1), down-count, no wrap used.
// STRUCTURE
//  sr_driver_pkg: typedef enum logic [1:0] {IDLE,PULSE,GAP,CHECK} sr_drv_state_t;
//   localparam CMD_SET=1'b1, CMD_RESET=1'b0.
//  Sub-module sr_pulse_timer: loadable down-counter (load, value, zero flag),
//   shared by PULSE and GAP phases.
// TESTING (bench instantiates sr_latch, q_fb<=q; PULSE_W=2, GAP_W=1)
//  1 rst 1 cycle, SET accepted -> s=1 cycles 1-2, r=0, gap cycle 3, done
//    cycle 4, q=1, q_exp=1, err=0.
//  2 SET again (SKIP=1) -> no s pulse, done at cycle 1, q stays 1.
//  3 RESET -> r=1 cycles 1-2, done cycle 4, q=0, q_exp=0, err=0.
//  4 q_fb forced 0, SET -> err=1 at done; stays 1 across next command;
//    rst -> err=0.
//  5 rst mid-PULSE -> s=0 next cycle, cmd_ready=1; next SET not skipped.
//  6 cmd_valid held, cmd_set alternating -> each cmd accepted once,
//    cmd_ready=0 while busy, never s&r; assertion on s&r every cycle.

Source files
------------

// File: rtl/sr_driver_pkg.sv
// Shared types and constants for the SR latch command driver.
//   sr_drv_state_t : driver FSM state encoding
//   CMD_SET/RESET  : cmd_set polarity
//   cnt_width()    : phase-timer width for given pulse/gap lengths
package sr_driver_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } sr_drv_state_t;

  localparam logic CMD_SET   = 1'b1;
  localparam logic CMD_RESET = 1'b0;

  // Bits needed to hold max(a, b); never less than one.
  function automatic int unsigned cnt_width(input int unsigned a, input int unsigned b);
    int unsigned m;
    m = (a > b) ? a : b;
    cnt_width = (m < 1) ? 1 : $clog2(m + 1);
  endfunction

endpackage : sr_driver_pkg

// File: rtl/sr_pulse_timer.sv
// Loadable down-counter timing the pulse and dead-time phases.
//   clk, rst     : clock, synchronous active-high reset
//   load_i       : load load_val_i (wins over dec_i)
//   load_val_i   : value to load (phase length minus one)
//   dec_i        : decrement when non-zero; holds at zero
//   zero_c       : counter currently zero (combinational decode)
module sr_pulse_timer #(
  parameter int unsigned CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic             dec_i,
  output logic             zero_c
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Next count: load has priority, decrement saturates at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_c = (cnt_q == '0);

endmodule : sr_pulse_timer

// File: rtl/sr_latch_driver.sv
// Command-side driver for an SR latch: converts set/reset commands into
// fixed-width s/r pulses followed by a dead time, then reads q back.
//   clk, rst            : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake, accepted only when idle
//   cmd_set             : 1 = SET (q->1), 0 = RESET (q->0)
//   s, r                : latch drives, registered, never both high
//   q_fb                : latch output read back in CHECK
//   busy                : command in flight
//   done                : one-cycle completion pulse (CHECK)
//   q_exp               : expected latch state after last completed command
//   err                 : sticky readback mismatch, cleared only by rst
module sr_latch_driver
  import sr_driver_pkg::*;
#(
  parameter int unsigned PULSE_W        = 2,
  parameter int unsigned GAP_W          = 1,
  parameter bit          SKIP_REDUNDANT = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic cmd_valid,
  input  logic cmd_set,
  output logic cmd_ready,
  output logic s,
  output logic r,
  input  logic q_fb,
  output logic busy,
  output logic done,
  output logic q_exp,
  output logic err
);

  localparam int unsigned CNT_W = cnt_width(PULSE_W, GAP_W);

  sr_drv_state_t    state_q, state_d;
  logic             s_q, s_d;
  logic             r_q, r_d;
  logic             cmd_q, cmd_d;
  logic             err_q, err_d;
  logic             q_exp_q, q_exp_d;
  logic             known_q, known_d;
  logic             done_q;
  logic             busy_q;
  logic             ready_q;

  logic             tmr_load;
  logic [CNT_W-1:0] tmr_val;
  logic             tmr_dec;
  logic             tmr_zero;
  logic             accept;

  assign accept = cmd_valid && (state_q == IDLE);

  // Next-state and output-next logic.
  always_comb begin
    state_d  = state_q;
    s_d      = 1'b0;
    r_d      = 1'b0;
    cmd_d    = cmd_q;
    err_d    = err_q;
    q_exp_d  = q_exp_q;
    known_d  = known_q;
    tmr_load = 1'b0;
    tmr_val  = '0;

    unique case (state_q)
      IDLE: begin
        if (accept) begin
          cmd_d = cmd_set;
          // Latch already known to hold the requested value: no pulse needed.
          if (SKIP_REDUNDANT && known_q && (cmd_set == q_exp_q)) begin
            state_d = CHECK;
          end else begin
            state_d  = PULSE;
            tmr_load = 1'b1;
            tmr_val  = CNT_W'(PULSE_W - 1);
            s_d      = (cmd_set == CMD_SET);
            r_d      = (cmd_set == CMD_RESET);
          end
        end
      end
      PULSE: begin
        if (tmr_zero) begin
          state_d  = GAP;
          tmr_load = 1'b1;
          tmr_val  = CNT_W'(GAP_W - 1);
        end else begin
          s_d = s_q;
          r_d = r_q;
        end
      end
      GAP: begin
        if (tmr_zero) begin
          state_d = CHECK;
        end
      end
      CHECK: begin
        if (q_fb != cmd_q) begin
          err_d = 1'b1;
        end
        q_exp_d = cmd_q;
        known_d = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Timer only runs while a timed phase is active and not being reloaded.
  assign tmr_dec = ((state_q == PULSE) || (state_q == GAP)) && !tmr_load;

  sr_pulse_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .dec_i      (tmr_dec),
    .zero_c     (tmr_zero)
  );

  // State and registered outputs; status flags follow the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      r_q     <= 1'b0;
      cmd_q   <= 1'b0;
      err_q   <= 1'b0;
      q_exp_q <= 1'b0;
      known_q <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      r_q     <= r_d;
      cmd_q   <= cmd_d;
      err_q   <= err_d;
      q_exp_q <= q_exp_d;
      known_q <= known_d;
      done_q  <= (state_d == CHECK);
      busy_q  <= (state_d != IDLE);
      ready_q <= (state_d == IDLE);
    end
  end

  assign cmd_ready = ready_q;
  assign s         = s_q;
  assign r         = r_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign q_exp     = q_exp_q;
  assign err       = err_q;

endmodule : sr_latch_driver

// File: tb/tb_sr_latch_driver.sv
// Bench for sr_latch_driver with a behavioural SR latch on the s/r outputs.
// Commands are checked against a transaction-level model of the driver.
module tb_sr_latch_driver;

  localparam int unsigned PW = 2;
  localparam int unsigned GW = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic cmd_valid = 1'b0;
  logic cmd_set = 1'b0;
  logic cmd_ready, s, r, busy, done, q_exp, err;
  logic q_fb;

  // Latch stand-in and optional readback override.
  logic lq = 1'b0;
  logic force_en = 1'b0;
  logic force_val = 1'b0;
  assign q_fb = force_en ? force_val : lq;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (s) lq <= 1'b1;
    else if (r) lq <= 1'b0;
  end

  sr_latch_driver #(
    .PULSE_W        (PW),
    .GAP_W          (GW),
    .SKIP_REDUNDANT (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_set   (cmd_set),
    .cmd_ready (cmd_ready),
    .s         (s),
    .r         (r),
    .q_fb      (q_fb),
    .busy      (busy),
    .done      (done),
    .q_exp     (q_exp),
    .err       (err)
  );

  int vectors = 0;
  int miscompares = 0;
  int accepts = 0;
  int issued = 0;

  // Model of the driver's architectural state and the latch.
  bit m_known = 0;
  bit m_qexp = 0;
  bit m_err = 0;
  bit m_lq = 0;

  task automatic check_val(input string tag, input int got, input int exp);
    vectors++;
    if (got != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    assert (!(s && r)) else $error("s and r both high");
    if (!rst && cmd_valid && cmd_ready) accepts++;
  end

  logic ps = 1'b0;
  logic pr = 1'b0;
  always @(negedge clk) begin
    check_val("s_and_r", int'(s & r), 0);
    check_val("sr_toggle", int'((s != ps) && (r != pr)), 0);
    ps = s;
    pr = r;
  end

  task automatic model_reset();
    m_known = 0;
    m_qexp = 0;
    m_err = 0;
  endtask

  // Called at a negedge with the driver idle; returns at a negedge, idle.
  task automatic do_cmd(input logic set, input bit hold);
    bit skip;
    bit seen;
    int exp_done;
    bit exp_s, exp_r;
    bit exp_qfb;
    skip = m_known && (set == m_qexp);
    exp_done = skip ? 1 : int'(PW + GW + 1);
    cmd_valid = 1'b1;
    cmd_set = set;
    check_val("ready_idle", int'(cmd_ready), 1);
    issued++;
    @(negedge clk);
    if (hold) cmd_set = ~set;
    else cmd_valid = 1'b0;
    seen = 0;
    for (int n = 1; n <= 20 && !seen; n++) begin
      if (n > 1) @(negedge clk);
      exp_s = !skip && set && (n <= int'(PW));
      exp_r = !skip && !set && (n <= int'(PW));
      check_val("s_pulse", int'(s), int'(exp_s));
      check_val("r_pulse", int'(r), int'(exp_r));
      check_val("ready_busy", int'(cmd_ready), 0);
      check_val("busy_on", int'(busy), 1);
      if (done) begin
        seen = 1;
        check_val("done_lat", n, exp_done);
      end
    end
    if (!seen) check_val("done_timeout", 0, 1);
    if (!skip) m_lq = set;
    exp_qfb = force_en ? force_val : m_lq;
    if (exp_qfb != set) m_err = 1;
    m_qexp = set;
    m_known = 1;
    @(negedge clk);
    check_val("done_clr", int'(done), 0);
    check_val("ready_back", int'(cmd_ready), 1);
    check_val("busy_clr", int'(busy), 0);
    check_val("q_exp", int'(q_exp), int'(m_qexp));
    check_val("err", int'(err), int'(m_err));
    check_val("latch_q", int'(lq), int'(m_lq));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cmd_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    check_val("rst_s", int'(s), 0);
    check_val("rst_r", int'(r), 0);
    check_val("rst_done", int'(done), 0);
    check_val("rst_busy", int'(busy), 0);
    check_val("rst_ready", int'(cmd_ready), 1);
    check_val("rst_err", int'(err), 0);
    check_val("rst_qexp", int'(q_exp), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(negedge clk);
    do_reset();

    // Basic SET, redundant SET, RESET.
    do_cmd(1'b1, 1'b0);
    do_cmd(1'b1, 1'b0);
    do_cmd(1'b0, 1'b0);

    // Readback forced low: err sets and sticks until reset.
    force_en = 1'b1;
    force_val = 1'b0;
    do_cmd(1'b1, 1'b0);
    do_cmd(1'b0, 1'b0);
    force_en = 1'b0;
    do_reset();

    // Reset in the middle of a pulse.
    cmd_valid = 1'b1;
    cmd_set = 1'b1;
    issued++;
    @(negedge clk);
    check_val("mid_s", int'(s), 1);
    cmd_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    m_lq = 1;
    check_val("mid_rst_s", int'(s), 0);
    check_val("mid_rst_ready", int'(cmd_ready), 1);
    check_val("mid_rst_busy", int'(busy), 0);
    do_cmd(1'b1, 1'b0);

    // Held valid with alternating command polarity.
    for (int i = 0; i < 6; i++) do_cmd(logic'(i % 2 == 0 ? 0 : 1), 1'b1);
    cmd_valid = 1'b0;
    @(negedge clk);

    // Randomised traffic.
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        force_en = 1'b0;
        do_reset();
      end else begin
        force_en = ($urandom_range(0, 4) == 0);
        force_val = logic'($urandom_range(0, 1));
        do_cmd(logic'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));
        cmd_valid = 1'b0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    end
    force_en = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);

    check_val("accept_count", accepts, issued);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule : tb_sr_latch_driver
